// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - four-digit seven-segment scan controller with dead-time blanking and frame-synchronous double buffer
module display_scan_ctrl #(
    parameter int PRESCALE = 50000,
    parameter int DEADTIME = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        on,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    output logic [1:0]  scan,
    output logic        E,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        pend,
    output logic        frame_done
);

    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LIT  = CW'(DEADTIME);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    slot_q, slot_d;

    logic [15:0]   st_data_q, st_data_d;
    logic [3:0]    st_dp_q, st_dp_d;
    logic [3:0]    st_blank_q, st_blank_d;
    logic [15:0]   sh_data_q, sh_data_d;
    logic [3:0]    sh_dp_q, sh_dp_d;
    logic [3:0]    sh_blank_q, sh_blank_d;
    logic          pend_q, pend_d;

    logic          wrap_q, wrap_d;
    logic [1:0]    scan_q, scan_d;
    logic          e_q, e_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          fd_q, fd_d;

    logic          slot_end;
    logic          boundary;
    logic          lit;
    logic [3:0]    digit;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign slot_end = (cnt_q == CNT_LAST);
    assign boundary = on & slot_end & (slot_q == 2'd3);

    always_comb begin
        cnt_d  = cnt_q;
        slot_d = slot_q;
        if (!on) begin
            cnt_d  = '0;
            slot_d = 2'd0;
        end else if (slot_end) begin
            cnt_d  = '0;
            slot_d = slot_q + 2'd1;
        end else begin
            cnt_d  = cnt_q + CW'(1);
        end
    end

    // A load on the boundary bypasses staging; while off, a pending update is applied immediately.
    always_comb begin
        st_data_d  = st_data_q;
        st_dp_d    = st_dp_q;
        st_blank_d = st_blank_q;
        sh_data_d  = sh_data_q;
        sh_dp_d    = sh_dp_q;
        sh_blank_d = sh_blank_q;
        pend_d     = pend_q;
        if (load) begin
            st_data_d  = data;
            st_dp_d    = dp_in;
            st_blank_d = blank;
            pend_d     = 1'b1;
        end
        if (boundary) begin
            if (load) begin
                sh_data_d  = data;
                sh_dp_d    = dp_in;
                sh_blank_d = blank;
            end else if (pend_q) begin
                sh_data_d  = st_data_q;
                sh_dp_d    = st_dp_q;
                sh_blank_d = st_blank_q;
            end
            pend_d = 1'b0;
        end else if (!on && pend_q) begin
            sh_data_d  = st_data_q;
            sh_dp_d    = st_dp_q;
            sh_blank_d = st_blank_q;
            pend_d     = load;
        end
    end

    assign digit = sh_data_q[{slot_q, 2'b00} +: 4];
    assign lit   = on & (cnt_q >= CNT_LIT) & ~sh_blank_q[slot_q];

    // Outputs are a one-cycle image of the scan state, so scan and E always move together.
    always_comb begin
        scan_d = slot_q;
        e_d    = lit;
        seg_d  = lit ? hex7(digit) : 7'h7F;
        dp_d   = lit ? ~sh_dp_q[slot_q] : 1'b1;
        wrap_d = boundary;
        fd_d   = wrap_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            slot_q     <= 2'd0;
            st_data_q  <= 16'h0000;
            st_dp_q    <= 4'h0;
            st_blank_q <= 4'hF;
            sh_data_q  <= 16'h0000;
            sh_dp_q    <= 4'h0;
            sh_blank_q <= 4'hF;
            pend_q     <= 1'b0;
            wrap_q     <= 1'b0;
            scan_q     <= 2'd0;
            e_q        <= 1'b0;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            fd_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            st_data_q  <= st_data_d;
            st_dp_q    <= st_dp_d;
            st_blank_q <= st_blank_d;
            sh_data_q  <= sh_data_d;
            sh_dp_q    <= sh_dp_d;
            sh_blank_q <= sh_blank_d;
            pend_q     <= pend_d;
            wrap_q     <= wrap_d;
            scan_q     <= scan_d;
            e_q        <= e_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            fd_q       <= fd_d;
        end
    end

    assign scan       = scan_q;
    assign E          = e_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign pend       = pend_q;
    assign frame_done = fd_q;

endmodule
